// File: rtl/multicore_completion_monitor.sv
// Per-core program-completion monitor for an N-core processor array.
// Each core gets an independent IDLE/RUN/DRAIN/DONE tracker. The tracker counts
// RUN cycles until the core's PC hits its finish address, waits for the pipeline
// to drain, then compares the selected result register against the expected
// value. A shared start pulse arms every core, but only while no core is busy.

module mcm_core #(
    parameter int ADDRESS_BITS   = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int CYCLE_BITS     = 32,
    parameter int DRAIN_CYCLES   = 50,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    start_i,        // already qualified by !busy
    input  logic [ADDRESS_BITS-1:0] pc_i,
    input  logic [ADDRESS_BITS-1:0] finish_pc_i,
    input  logic [DATA_WIDTH-1:0]   check_value_i,
    input  logic [DATA_WIDTH-1:0]   expected_value_i,
    output logic [CYCLE_BITS-1:0]   cycles_o,
    output logic                    done_o,
    output logic                    pass_o,
    output logic                    timeout_o,
    output logic                    active_o
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Drain counter only needs to hold DRAIN_CYCLES-1.
    localparam int DRW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRW-1:0] DRAIN_LOAD = DRW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    localparam logic [CYCLE_BITS-1:0] CYC_MAX = '1;
    // Timeout is only meaningful when the final count fits in the counter.
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0) &&
                           (64'(TIMEOUT_CYCLES) < (64'd1 << CYCLE_BITS));
    localparam logic [CYCLE_BITS-1:0] TO_LAST  = CYCLE_BITS'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CYCLE_BITS-1:0] TO_FINAL = CYCLE_BITS'(TO_EN ? TIMEOUT_CYCLES : 0);

    logic [1:0]            state_q, state_d;
    logic [CYCLE_BITS-1:0] cycles_q, cycles_d;
    logic [DRW-1:0]        drain_q, drain_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic                  timeout_q, timeout_d;
    logic                  match;

    assign match = (pc_i == finish_pc_i);

    // Next-state: arm on start, count/match/timeout in RUN, count down in DRAIN.
    always_comb begin
        state_d   = state_q;
        cycles_d  = cycles_q;
        drain_d   = drain_q;
        done_d    = done_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d   = S_RUN;
                    cycles_d  = '0;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            S_RUN: begin
                if (match) begin
                    // cycles freezes at its current value on the match cycle
                    if (DRAIN_CYCLES == 0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        pass_d  = (check_value_i == expected_value_i);
                    end else begin
                        state_d = S_DRAIN;
                        drain_d = DRAIN_LOAD;
                    end
                end else if (TO_EN && (cycles_q == TO_LAST)) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                    cycles_d  = TO_FINAL;
                end else if (cycles_q != CYC_MAX) begin
                    cycles_d = cycles_q + CYCLE_BITS'(1);
                end
            end
            S_DRAIN: begin
                // pc is ignored here; the result is sampled when the count hits 0
                if (drain_q == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    pass_d  = (check_value_i == expected_value_i);
                end else begin
                    drain_d = drain_q - DRW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset discards any in-flight run without sampling.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            cycles_q  <= '0;
            drain_q   <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cycles_q  <= cycles_d;
            drain_q   <= drain_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
        end
    end

    assign cycles_o  = cycles_q;
    assign done_o    = done_q;
    assign pass_o    = pass_q;
    assign timeout_o = timeout_q;
    assign active_o  = (state_q == S_RUN) || (state_q == S_DRAIN);
endmodule

module multicore_completion_monitor #(
    parameter int NUM_CORES      = 2,
    parameter int ADDRESS_BITS   = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int CYCLE_BITS     = 32,
    parameter int DRAIN_CYCLES   = 50,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                              clock_i,
    input  logic                              reset_i,
    input  logic                              start_i,
    input  logic [NUM_CORES*ADDRESS_BITS-1:0] pc_i,
    input  logic [NUM_CORES*ADDRESS_BITS-1:0] finish_pc_i,
    input  logic [NUM_CORES*DATA_WIDTH-1:0]   check_value_i,
    input  logic [NUM_CORES*DATA_WIDTH-1:0]   expected_value_i,
    output logic [NUM_CORES*CYCLE_BITS-1:0]   cycles_o,
    output logic [NUM_CORES-1:0]              core_done_o,
    output logic [NUM_CORES-1:0]              core_pass_o,
    output logic [NUM_CORES-1:0]              core_timeout_o,
    output logic                              busy_o,
    output logic                              all_done_o,
    output logic                              all_pass_o
);
    logic [NUM_CORES-1:0] active;
    logic                 start_ok;

    // A start while any core is still running or draining is dropped.
    assign start_ok = start_i & ~busy_o;

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
        mcm_core #(
            .ADDRESS_BITS  (ADDRESS_BITS),
            .DATA_WIDTH    (DATA_WIDTH),
            .CYCLE_BITS    (CYCLE_BITS),
            .DRAIN_CYCLES  (DRAIN_CYCLES),
            .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
        ) u_core (
            .clock_i         (clock_i),
            .reset_i         (reset_i),
            .start_i         (start_ok),
            .pc_i            (pc_i[g*ADDRESS_BITS +: ADDRESS_BITS]),
            .finish_pc_i     (finish_pc_i[g*ADDRESS_BITS +: ADDRESS_BITS]),
            .check_value_i   (check_value_i[g*DATA_WIDTH +: DATA_WIDTH]),
            .expected_value_i(expected_value_i[g*DATA_WIDTH +: DATA_WIDTH]),
            .cycles_o        (cycles_o[g*CYCLE_BITS +: CYCLE_BITS]),
            .done_o          (core_done_o[g]),
            .pass_o          (core_pass_o[g]),
            .timeout_o       (core_timeout_o[g]),
            .active_o        (active[g])
        );
    end

    assign busy_o     = |active;
    assign all_done_o = &core_done_o;
    assign all_pass_o = all_done_o & (&core_pass_o);
endmodule

// File: tb/tb_multicore_completion_monitor.sv
// Bench for multicore_completion_monitor. Two instances: A (drain 50, timeout 100,
// 32-bit counters) and B (no drain, no timeout, 4-bit counters). A timestamp
// model predicts every output each cycle; literal checks pin key results.
module tb_multicore_completion_monitor;
    localparam int NC = 2, AW = 32, DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic                st   [2];
    logic [NC*AW-1:0]    pc   [2];
    logic [NC*AW-1:0]    fpc  [2];
    logic [NC*DW-1:0]    chk  [2];
    logic [NC*DW-1:0]    expv [2];
    logic [NC*32-1:0]    cyc_a;
    logic [NC*4-1:0]     cyc_b;
    logic [NC-1:0]       dn   [2];
    logic [NC-1:0]       ps   [2];
    logic [NC-1:0]       tmo  [2];
    logic                bz   [2];
    logic                ad   [2];
    logic                ap   [2];

    int n_cmp = 0, n_bad = 0;
    bit cmp_on = 0;

    multicore_completion_monitor #(
        .NUM_CORES(NC), .ADDRESS_BITS(AW), .DATA_WIDTH(DW),
        .CYCLE_BITS(32), .DRAIN_CYCLES(50), .TIMEOUT_CYCLES(100)
    ) u_a (
        .clock_i(clk), .reset_i(rst), .start_i(st[0]),
        .pc_i(pc[0]), .finish_pc_i(fpc[0]),
        .check_value_i(chk[0]), .expected_value_i(expv[0]),
        .cycles_o(cyc_a), .core_done_o(dn[0]), .core_pass_o(ps[0]),
        .core_timeout_o(tmo[0]), .busy_o(bz[0]), .all_done_o(ad[0]), .all_pass_o(ap[0])
    );

    multicore_completion_monitor #(
        .NUM_CORES(NC), .ADDRESS_BITS(AW), .DATA_WIDTH(DW),
        .CYCLE_BITS(4), .DRAIN_CYCLES(0), .TIMEOUT_CYCLES(0)
    ) u_b (
        .clock_i(clk), .reset_i(rst), .start_i(st[1]),
        .pc_i(pc[1]), .finish_pc_i(fpc[1]),
        .check_value_i(chk[1]), .expected_value_i(expv[1]),
        .cycles_o(cyc_b), .core_done_o(dn[1]), .core_pass_o(ps[1]),
        .core_timeout_o(tmo[1]), .busy_o(bz[1]), .all_done_o(ad[1]), .all_pass_o(ap[1])
    );

    // ---------------- model: per-core run timestamps ----------------
    bit     act  [2][NC];   // run in progress (RUN or drain window)
    int     rel  [2][NC];   // RUN-relative cycle index
    int     mrel [2][NC];   // cycle index of first match, -1 if none
    longint e_cyc[2][NC];
    bit     e_dn [2][NC];
    bit     e_ps [2][NC];
    bit     e_to [2][NC];

    function automatic int drain_of(int u); return (u == 0) ? 50 : 0; endfunction
    function automatic int to_of(int u);    return (u == 0) ? 100 : 0; endfunction
    function automatic longint sat_of(int u);
        return (u == 0) ? 64'hFFFF_FFFF : 64'hF;
    endfunction

    // Advance the model by one clock edge using the inputs that edge will sample.
    task automatic model_step();
        bit bsy, pm;
        longint nxt;
        for (int u = 0; u < 2; u++) begin
            bsy = 0;
            for (int i = 0; i < NC; i++) bsy |= act[u][i];
            if (rst) begin
                for (int i = 0; i < NC; i++) begin
                    act[u][i] = 0; rel[u][i] = 0; mrel[u][i] = -1;
                    e_cyc[u][i] = 0; e_dn[u][i] = 0; e_ps[u][i] = 0; e_to[u][i] = 0;
                end
            end else begin
                for (int i = 0; i < NC; i++) begin
                    if (act[u][i]) begin
                        pm = (pc[u][i*AW +: AW] == fpc[u][i*AW +: AW]);
                        if (mrel[u][i] < 0) begin
                            if (pm) mrel[u][i] = rel[u][i];
                            else if (to_of(u) > 0 && rel[u][i] == to_of(u) - 1) begin
                                act[u][i] = 0; e_dn[u][i] = 1; e_to[u][i] = 1;
                                e_ps[u][i] = 0; e_cyc[u][i] = to_of(u);
                            end else begin
                                nxt = longint'(rel[u][i]) + 1;
                                e_cyc[u][i] = (nxt > sat_of(u)) ? sat_of(u) : nxt;
                            end
                        end
                        if (act[u][i] && mrel[u][i] >= 0 && rel[u][i] == mrel[u][i] + drain_of(u)) begin
                            act[u][i] = 0; e_dn[u][i] = 1;
                            e_ps[u][i] = (chk[u][i*DW +: DW] == expv[u][i*DW +: DW]);
                        end
                        rel[u][i]++;
                    end
                end
                if (st[u] && !bsy) begin
                    for (int i = 0; i < NC; i++) begin
                        act[u][i] = 1; rel[u][i] = 0; mrel[u][i] = -1;
                        e_cyc[u][i] = 0; e_dn[u][i] = 0; e_ps[u][i] = 0; e_to[u][i] = 0;
                    end
                end
            end
        end
    endtask

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    function automatic logic [63:0] got_cyc(int u, int i);
        if (u == 0) return {32'b0, cyc_a[i*32 +: 32]};
        return {60'b0, cyc_b[i*4 +: 4]};
    endfunction

    // Compare DUT against model mid-cycle, then advance the model.
    always @(negedge clk) begin
        bit any_act, all_dn, all_ps;
        if (cmp_on) begin
            for (int u = 0; u < 2; u++) begin
                any_act = 0; all_dn = 1; all_ps = 1;
                for (int i = 0; i < NC; i++) begin
                    check($sformatf("u%0d.cycles%0d", u, i), got_cyc(u, i), 64'(e_cyc[u][i]));
                    check($sformatf("u%0d.done%0d", u, i), 64'(dn[u][i]), 64'(e_dn[u][i]));
                    check($sformatf("u%0d.pass%0d", u, i), 64'(ps[u][i]), 64'(e_ps[u][i]));
                    check($sformatf("u%0d.timeout%0d", u, i), 64'(tmo[u][i]), 64'(e_to[u][i]));
                    any_act |= act[u][i]; all_dn &= e_dn[u][i]; all_ps &= e_ps[u][i];
                end
                check($sformatf("u%0d.busy", u), 64'(bz[u]), 64'(any_act));
                check($sformatf("u%0d.all_done", u), 64'(ad[u]), 64'(all_dn));
                check($sformatf("u%0d.all_pass", u), 64'(ap[u]), 64'(all_dn & all_ps));
            end
        end
        model_step();
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int u);
        st[u] = 1'b1;
        step(1);
        st[u] = 1'b0;
    endtask

    task automatic wait_all_done(input int u, input int limit, input string nm);
        int k = 0;
        while (ad[u] !== 1'b1 && k < limit) begin
            @(negedge clk);
            k++;
        end
        if (ad[u] !== 1'b1) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: all_done not seen within %0d cycles", nm, limit);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            st[u] = 1'b0; pc[u] = '0; fpc[u] = '0; chk[u] = '0; expv[u] = '0;
        end
        step(2);
        cmp_on = 1;
        rst = 1'b0;
        @(negedge clk);
        check("reset.cycles_a", {32'b0, cyc_a}, 64'h0);
        check("reset.done_a", 64'(dn[0]), 64'h0);
        check("reset.busy_a", 64'(bz[0]), 64'h0);
        check("reset.all_done_a", 64'(ad[0]), 64'h0);

        // Test 1: core0 matches 0xB0 after 20 cycles, core1 0x168 after 40.
        fpc[0] = {32'h168, 32'hB0};
        pulse_start(0);
        step(20); pc[0][31:0]  = 32'hB0;
        step(20); pc[0][63:32] = 32'h168;
        step(30);
        @(negedge clk);
        check("t1.done0_early", 64'(dn[0][0]), 64'h0);
        step(1);
        @(negedge clk);
        check("t1.done0_at_drain_end", 64'(dn[0][0]), 64'h1);
        wait_all_done(0, 200, "t1.wait");
        check("t1.cycles0", {32'b0, cyc_a[31:0]}, 64'd20);
        check("t1.cycles1", {32'b0, cyc_a[63:32]}, 64'd40);
        check("t1.all_pass", 64'(ap[0]), 64'h1);

        // Test 2: core1 result wrong.
        pc[0] = '0; chk[0][63:32] = 32'h7B;
        pulse_start(0);
        step(20); pc[0][31:0]  = 32'hB0;
        step(20); pc[0][63:32] = 32'h168;
        wait_all_done(0, 200, "t2.wait");
        check("t2.core_pass", 64'(ps[0]), 64'b01);
        check("t2.all_pass", 64'(ap[0]), 64'h0);

        // Test 3: core1 never matches -> timeout at 100.
        pc[0] = '0; chk[0] = '0;
        pulse_start(0);
        step(20); pc[0][31:0] = 32'hB0;
        wait_all_done(0, 300, "t3.wait");
        check("t3.timeout", 64'(tmo[0]), 64'b10);
        check("t3.cycles1", {32'b0, cyc_a[63:32]}, 64'd100);
        check("t3.core_pass", 64'(ps[0]), 64'b01);

        // Test 5: start during RUN ignored, reset during DRAIN, fresh rerun.
        pc[0] = '0;
        pulse_start(0);
        step(10); st[0] = 1'b1;
        step(1);  st[0] = 1'b0;
        @(negedge clk);
        check("t5.cycles_not_cleared", {32'b0, cyc_a[31:0]}, 64'd11);
        step(19); pc[0][31:0] = 32'hB0;
        step(10); rst = 1'b1;
        step(1);  rst = 1'b0;
        @(negedge clk);
        check("t5.rst_cycles", {32'b0, cyc_a}, 64'h0);
        check("t5.rst_done", 64'(dn[0]), 64'h0);
        check("t5.rst_busy", 64'(bz[0]), 64'h0);
        pc[0] = '0;
        pulse_start(0);
        step(5); pc[0][31:0]  = 32'hB0;
        step(2); pc[0][63:32] = 32'h168;
        wait_all_done(0, 200, "t5.wait");
        check("t5.cycles0", {32'b0, cyc_a[31:0]}, 64'd5);
        check("t5.cycles1", {32'b0, cyc_a[63:32]}, 64'd7);

        // Instance B: no drain, immediate match, 4-bit saturation.
        fpc[1]  = {32'h40, 32'h40};
        pc[1]   = {32'h0, 32'h40};
        chk[1]  = {32'h5, 32'h11};
        expv[1] = {32'h5, 32'h11};
        pulse_start(1);
        @(negedge clk);
        check("b.done0_first_cycle", 64'(dn[1][0]), 64'h0);
        step(1); chk[1][31:0] = 32'h22;
        @(negedge clk);
        check("b.done0", 64'(dn[1][0]), 64'h1);
        check("b.cycles0", {60'b0, cyc_b[3:0]}, 64'h0);
        check("b.pass0_sampled_on_match", 64'(ps[1][0]), 64'h1);
        step(19); pc[1][63:32] = 32'h40;
        wait_all_done(1, 50, "b.wait");
        check("b.cycles1_sat", {60'b0, cyc_b[7:4]}, 64'hF);
        check("b.timeout", 64'(tmo[1]), 64'h0);

        step(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/multicore_completion_monitor.md
Name: multicore_completion_monitor

Overview:
Synthesizable per-core program-completion monitor for the N-core single-cycle processor array. It moves the bench-side finish detection into hardware: per-core PC-match, cycle counting, pipeline drain wait, result-register check and timeout. It sits beside the core array, snooping the concatenated PC bus and a selected per-core register value. The aggregated done/pass flags drive the top-level status and the scan/debug logic.

Parameters:
NUM_CORES, 2, number of monitored cores (1..16)
ADDRESS_BITS, 32, PC width
DATA_WIDTH, 32, width of checked register value
CYCLE_BITS, 32, width of each per-core cycle counter
DRAIN_CYCLES, 50, cycles to wait after PC match before sampling the check value (0 = sample on match cycle)
TIMEOUT_CYCLES, 1000, RUN-cycle limit per core (0 = timeout disabled)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; clears all state
start  input  1  one-cycle pulse; arms all cores
pc  input  NUM_CORES*ADDRESS_BITS  core i PC at [i*ADDRESS_BITS +: ADDRESS_BITS]
finish_pc  input  NUM_CORES*ADDRESS_BITS  per-core finish address, same packing
check_value  input  NUM_CORES*DATA_WIDTH  per-core result register (e.g. x9), packed
expected_value  input  NUM_CORES*DATA_WIDTH  per-core expected result, packed
cycles  output  NUM_CORES*CYCLE_BITS  per-core frozen run-time count, packed
core_done  output  NUM_CORES  core reached DONE
core_pass  output  NUM_CORES  sampled check_value == expected_value
core_timeout  output  NUM_CORES  core hit TIMEOUT_CYCLES without match
busy  output  1  any core in RUN or DRAIN
all_done  output  1  &core_done
all_pass  output  1  all_done & (&core_pass)

Behaviour:
- Reset: every core FSM to IDLE; cycles, core_done, core_pass, core_timeout, busy, all_done, all_pass all 0.
- Per-core FSM states: IDLE, RUN, DRAIN, DONE; one independent instance per core, shared start.
- start accepted only when busy=0 (from all-IDLE or all-DONE). On acceptance, in the next cycle every core is in RUN, cycles=0, and done/pass/timeout are cleared. start while busy=1 is ignored.
- RUN: every cycle where pc_i != finish_pc_i, cycles_i += 1, saturating at all-ones. On the first cycle where pc_i == finish_pc_i, cycles_i freezes at its current value. Match on the first RUN cycle gives cycles_i=0.
- RUN to DRAIN on match, when DRAIN_CYCLES>0. The drain counter is loaded with DRAIN_CYCLES-1.
- RUN to DONE directly on match when DRAIN_CYCLES=0. check_value_i is sampled on the match cycle.
- DRAIN: counter decrements each cycle and pc_i is ignored. On the cycle the counter reads 0, sample check_value_i; next state DONE. DRAIN therefore lasts exactly DRAIN_CYCLES cycles.
- DONE: core_done_i=1; core_pass_i = (sampled == expected_value_i). Outputs hold until reset or an accepted start.
- Timeout (TIMEOUT_CYCLES>0): in RUN, if there is no match and cycles_i == TIMEOUT_CYCLES-1, go to DONE on the next edge with core_timeout_i=1, core_pass_i=0 and cycles_i=TIMEOUT_CYCLES. Match and timeout on the same cycle: match wins.
- Flag timing: all flags and cycles are registered and visible the cycle after the state transition. all_done/all_pass are combinational from the registered flags.
- Reset asserted mid-RUN or mid-DRAIN: immediate return to the reset state on that edge, with no partial sampling.
- Widths: compare is full-width equality; counters never wrap.

Test Plan:
- NUM_CORES=2, DRAIN_CYCLES=50: start; core0 pc matches 0xB0 after 20 RUN cycles, core1 matches 0x168 after 40; check=0 and expected=0 for both -> cycles={40,20}; core0_done 50 cycles after its match; all_done=1 after core1 drains; all_pass=1.
- Same setup with core1 check_value=0x7B, expected=0 -> core_pass=2'b01, all_done=1, all_pass=0.
- TIMEOUT_CYCLES=100, core1 never matches -> core_timeout=2'b10, cycles1=100, core_pass[1]=0; core0 completes normally.
- DRAIN_CYCLES=0, match on first RUN cycle -> cycles=0; core_done set one cycle later; check_value sampled on the match cycle.
- Reset pulsed during DRAIN, then a new start -> all outputs 0 after reset; the second run completes with fresh counts; a start during RUN is ignored (cycles not cleared).
- CYCLE_BITS=4, TIMEOUT_CYCLES=0, match after 20 cycles -> cycles saturates at 0xF, no wrap, core_timeout=0.
